// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary to 8-digit packed BCD converter, one bit per clock.
// Optional leading-zero blanking of the loaded result when BIN2BCD_BLANK_EN is defined.
//
// state | meaning
// IDLE  | waiting for start, busy=0
// CONV  | one add-3/shift step per clock, BIN_W steps
// LOAD  | register result into bcd/ovf, pulse done next cycle
module bin2bcd_seq #(
  parameter int BIN_W = 27
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic [31:0]      bcd,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [BIN_W-1:0] shreg;
  logic [31:0]      scratch;
  logic [31:0]      scratch_adj;
  logic [31:0]      load_val;
  logic [5:0]       cnt;
  logic             ovf_lat;
  logic [31:0]      bin_ext;

  assign bin_ext = 32'(bin);

  function automatic logic [31:0] add3(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    for (int i = 0; i < 8; i++) begin
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign scratch_adj = add3(scratch);

`ifdef BIN2BCD_BLANK_EN
  // Blank every zero digit above the most significant non-zero one; digit 0 always shown.
  always_comb begin
    logic seen;
    load_val = scratch;
    seen     = 1'b0;
    for (int i = 7; i >= 1; i--) begin
      if (scratch[4*i +: 4] != 4'd0) seen = 1'b1;
      if (!seen) load_val[4*i +: 4] = 4'hF;
    end
  end
`else
  assign load_val = scratch;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = CONV;
      CONV: begin
        busy = 1'b1;
        if (cnt == 6'd1) state_nxt = LOAD;
      end
      LOAD: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      scratch <= '0;
      cnt     <= '0;
      ovf_lat <= 1'b0;
      bcd     <= '0;
      ovf     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg   <= bin;
            scratch <= '0;
            cnt     <= 6'(BIN_W);
            ovf_lat <= (bin_ext > 32'd99_999_999);
          end
        end
        CONV: begin
          // Bits shifted out of digit 7 are dropped; ovf saturation covers that range.
          scratch <= {scratch_adj[30:0], shreg[BIN_W-1]};
          shreg   <= shreg << 1;
          cnt     <= cnt - 6'd1;
        end
        LOAD: begin
          bcd  <= ovf_lat ? 32'h9999_9999 : load_val;
          ovf  <= ovf_lat;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed corner values, start-while-busy,
// back-to-back, reset abort and randomized values against a decimal reference model.
module tb_bin2bcd_seq;

  localparam int BIN_W = 27;
  localparam int LAT   = BIN_W + 1;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [BIN_W-1:0] bin;
  logic [31:0]      bcd;
  logic             busy;
  logic             done;
  logic             ovf;

  int n_checks = 0;
  int n_fail   = 0;

  bin2bcd_seq #(.BIN_W(BIN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin),
    .bcd   (bcd),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decimal digits by division, saturating above eight digits.
  function automatic logic [31:0] ref_bcd(input longint v);
    logic [31:0] r;
    longint      x;
    int          top;
    if (v > 64'd99_999_999) return 32'h9999_9999;
    r   = '0;
    x   = v;
    top = 0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      if (x % 10 != 0) top = i;
      x = x / 10;
    end
`ifdef BIN2BCD_BLANK_EN
    for (int i = 1; i < 8; i++) if (i > top) r[4*i +: 4] = 4'hF;
`endif
    return r;
  endfunction

  function automatic logic ref_ovf(input longint v);
    return v > 64'd99_999_999;
  endfunction

  // Drives one conversion and measures it; comparisons are done by the callers.
  task automatic do_conv(input logic [BIN_W-1:0] v, output int lat, output int busy_cnt,
                         output logic [31:0] r_bcd, output logic r_ovf,
                         output logic one_pulse, output logic held, output logic overlap);
    logic [31:0] prev;
    @(negedge clk);
    prev  = bcd;
    bin   = v;
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    bin      = BIN_W'($urandom);
    lat      = 0;
    busy_cnt = 0;
    held     = 1'b1;
    while (!done && lat < 60) begin
      if (busy) busy_cnt++;
      if (bcd !== prev) held = 1'b0;
      @(negedge clk);
      lat++;
    end
    overlap = busy & done;
    r_bcd   = bcd;
    r_ovf   = ovf;
    @(negedge clk);
    one_pulse = !done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bcd !== 32'h0) begin n_fail++; $display("FAIL reset_bcd got %h want 00000000", bcd); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", ovf); end
  endtask

  task automatic test_directed();
    logic [BIN_W-1:0] vals [7];
    int lat, bc;
    logic [31:0] rb;
    logic ro, op, hd, ov;
    vals = '{27'd0, 27'd12_345_678, 27'd99_999_999, 27'd1_005,
             27'd134_217_727, 27'd100_000_000, 27'd7};
    foreach (vals[k]) begin
      do_conv(vals[k], lat, bc, rb, ro, op, hd, ov);
      n_checks++;
      if (rb !== ref_bcd(longint'(vals[k]))) begin
        n_fail++; $display("FAIL dir_bcd bin=%0d got %h want %h", vals[k], rb, ref_bcd(longint'(vals[k])));
      end
      n_checks++;
      if (ro !== ref_ovf(longint'(vals[k]))) begin
        n_fail++; $display("FAIL dir_ovf bin=%0d got %b want %b", vals[k], ro, ref_ovf(longint'(vals[k])));
      end
      n_checks++;
      if (lat != LAT) begin n_fail++; $display("FAIL dir_latency bin=%0d got %0d want %0d", vals[k], lat, LAT); end
      n_checks++;
      if (bc != LAT) begin n_fail++; $display("FAIL dir_busy_cycles bin=%0d got %0d want %0d", vals[k], bc, LAT); end
      n_checks++;
      if (!op) begin n_fail++; $display("FAIL dir_done_width bin=%0d got >1 cycle want 1", vals[k]); end
      n_checks++;
      if (!hd) begin n_fail++; $display("FAIL dir_bcd_held bin=%0d got change during conv want stable", vals[k]); end
      n_checks++;
      if (ov) begin n_fail++; $display("FAIL dir_busy_done_overlap bin=%0d got 1 want 0", vals[k]); end
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    @(negedge clk);
    bin   = 27'd24_681_357;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 60) begin
      start = (lat == 5 || lat == 20);
      bin   = start ? 27'd11_111_111 : BIN_W'($urandom);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    n_checks++;
    if (bcd !== ref_bcd(64'd24_681_357)) begin
      n_fail++; $display("FAIL ignore_bcd got %h want %h", bcd, ref_bcd(64'd24_681_357));
    end
    n_checks++;
    if (lat != LAT) begin n_fail++; $display("FAIL ignore_latency got %0d want %0d", lat, LAT); end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_no_queue got busy=%b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    bin   = 27'd3_141_592;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 60) begin @(negedge clk); lat++; end
    n_checks++;
    if (bcd !== ref_bcd(64'd3_141_592)) begin
      n_fail++; $display("FAIL b2b_first_bcd got %h want %h", bcd, ref_bcd(64'd3_141_592));
    end
    bin   = 27'd27_182_818;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got busy=%b want 1", busy); end
    lat = 0;
    while (!done && lat < 60) begin @(negedge clk); lat++; end
    n_checks++;
    if (lat != LAT) begin n_fail++; $display("FAIL b2b_latency got %0d want %0d", lat, LAT); end
    n_checks++;
    if (bcd !== ref_bcd(64'd27_182_818)) begin
      n_fail++; $display("FAIL b2b_second_bcd got %h want %h", bcd, ref_bcd(64'd27_182_818));
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int lat, bc, stray;
    logic [31:0] rb;
    logic ro, op, hd, ov;
    @(negedge clk);
    bin   = 27'd100_000_001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bcd !== 32'h0) begin n_fail++; $display("FAIL abort_bcd got %h want 00000000", bcd); end
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL abort_flags got busy=%b done=%b ovf=%b want 000", busy, done, ovf);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    repeat (40) begin @(negedge clk); if (done || busy) stray++; end
    n_checks++;
    if (stray != 0) begin n_fail++; $display("FAIL abort_no_done got %0d active cycles want 0", stray); end
    do_conv(27'd42, lat, bc, rb, ro, op, hd, ov);
    n_checks++;
    if (rb !== ref_bcd(64'd42) || ro !== 1'b0 || lat != LAT) begin
      n_fail++; $display("FAIL abort_recover got bcd=%h ovf=%b lat=%0d want bcd=%h ovf=0 lat=%0d",
                         rb, ro, lat, ref_bcd(64'd42), LAT);
    end
  endtask

  task automatic test_random();
    logic [BIN_W-1:0] v;
    int lat, bc;
    logic [31:0] rb;
    logic ro, op, hd, ov;
    for (int n = 0; n < 40; n++) begin
      if (n % 2 == 0) v = BIN_W'($urandom_range(99_999_999, 0));
      else            v = BIN_W'($urandom);
      do_conv(v, lat, bc, rb, ro, op, hd, ov);
      n_checks++;
      if (rb !== ref_bcd(longint'(v)) || ro !== ref_ovf(longint'(v))) begin
        n_fail++; $display("FAIL rand_result bin=%0d got bcd=%h ovf=%b want bcd=%h ovf=%b",
                           v, rb, ro, ref_bcd(longint'(v)), ref_ovf(longint'(v)));
      end
      n_checks++;
      if (lat != LAT || bc != LAT || !op || ov) begin
        n_fail++; $display("FAIL rand_timing bin=%0d got lat=%0d busy=%0d single=%b overlap=%b want %0d %0d 1 0",
                           v, lat, bc, op, ov, LAT, LAT);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
